// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: issue-side reservation/queries, two writeback sources,
// and the registered register-file write port.
interface regfile_wb_scheduler_if #(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned DATA_W = 32
);
    logic              allocValid;
    logic [IDX_W-1:0]  allocIndex;
    logic              allocReady;
    logic [IDX_W-1:0]  rs1Index;
    logic [IDX_W-1:0]  rs2Index;
    logic              rs1Busy;
    logic              rs2Busy;
    logic              aluValid;
    logic [IDX_W-1:0]  aluIndex;
    logic [DATA_W-1:0] aluData;
    logic              aluReady;
    logic              lsuValid;
    logic [IDX_W-1:0]  lsuIndex;
    logic [DATA_W-1:0] lsuData;
    logic              lsuReady;
    logic              we;
    logic [IDX_W-1:0]  writeIndex;
    logic [DATA_W-1:0] data;

    modport master (
        output allocValid, allocIndex, rs1Index, rs2Index,
        output aluValid, aluIndex, aluData, lsuValid, lsuIndex, lsuData,
        input  allocReady, rs1Busy, rs2Busy, aluReady, lsuReady,
        input  we, writeIndex, data
    );

    modport slave (
        input  allocValid, allocIndex, rs1Index, rs2Index,
        input  aluValid, aluIndex, aluData, lsuValid, lsuIndex, lsuData,
        output allocReady, rs1Busy, rs2Busy, aluReady, lsuReady,
        output we, writeIndex, data
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register-file write port between ALU and LSU,
// with a busy scoreboard for RAW/WAW stalls at issue.
module regfile_wb_scheduler #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_scheduler_if.slave  wb
);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    write_index_q, write_index_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                grant_alu, grant_lsu, alloc_ready, alloc_fire;
    logic [IDX_W-1:0]    sel_index;
    logic [DATA_W-1:0]   sel_data;

    // Arbitration and reservation acceptance; nothing is granted during reset.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!reset) begin
            if (wb.aluValid && wb.lsuValid) begin
                grant_alu = (last_grant_q == SRC_LSU);
                grant_lsu = !grant_alu;
            end else begin
                grant_alu = wb.aluValid;
                grant_lsu = wb.lsuValid;
            end
        end
        sel_index   = grant_lsu ? wb.lsuIndex : wb.aluIndex;
        sel_data    = grant_lsu ? wb.lsuData  : wb.aluData;
        alloc_ready = !reset && ((wb.allocIndex == '0) || !busy_q[wb.allocIndex]);
        alloc_fire  = wb.allocValid && alloc_ready && (wb.allocIndex != '0);
    end

    // Next state: clear the bit being written this cycle, set newly reserved bit.
    always_comb begin
        busy_d        = busy_q;
        last_grant_d  = last_grant_q;
        we_d          = 1'b0;
        write_index_d = write_index_q;
        data_d        = data_q;
        if (we_q) begin
            busy_d[write_index_q] = 1'b0;
        end
        if (alloc_fire) begin
            busy_d[wb.allocIndex] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (grant_alu || grant_lsu) begin
            last_grant_d = grant_lsu ? SRC_LSU : SRC_ALU;
            // Writes to x0 are accepted but never reach the register file.
            if (sel_index != '0) begin
                we_d          = 1'b1;
                write_index_d = sel_index;
                data_d        = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q        <= '0;
            last_grant_q  <= SRC_LSU;
            we_q          <= 1'b0;
            write_index_q <= '0;
            data_q        <= '0;
        end else begin
            busy_q        <= busy_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            write_index_q <= write_index_d;
            data_q        <= data_d;
        end
    end

    assign wb.allocReady = alloc_ready;
    assign wb.rs1Busy    = busy_q[wb.rs1Index];
    assign wb.rs2Busy    = busy_q[wb.rs2Index];
    assign wb.aluReady   = grant_alu;
    assign wb.lsuReady   = grant_lsu;
    assign wb.we         = we_q;
    assign wb.writeIndex = write_index_q;
    assign wb.data       = data_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized scoreboard bench for regfile_wb_scheduler against a behavioural model.
module tb_regfile_wb_scheduler;
    logic clk;
    logic reset;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] dat;
    } wr_t;

    wr_t   exp_q[$];
    wr_t   e;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // Reference model state
    bit          mb[32];
    bit          last_was_lsu;
    bit          out_we;
    logic [4:0]  out_idx;

    // Source and issue stimulus state
    bit          alu_pend, lsu_pend;
    logic [4:0]  alu_i, lsu_i;
    logic [31:0] alu_d, lsu_d;
    bit          s_rst, s_av;
    logic [4:0]  s_ai, s_r1, s_r2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic new_alu(input logic [4:0] idx, input logic [31:0] dat);
        alu_pend = 1'b1; alu_i = idx; alu_d = dat;
    endtask

    task automatic new_lsu(input logic [4:0] idx, input logic [31:0] dat);
        lsu_pend = 1'b1; lsu_i = idx; lsu_d = dat;
    endtask

    task automatic idle_inputs();
        s_rst = 1'b0; s_av = 1'b0; s_ai = 5'd0; s_r1 = 5'd0; s_r2 = 5'd0;
    endtask

    // One cycle: drive, check combinational outputs, advance the model.
    task automatic step();
        bit          ar, ga, gl;
        logic [4:0]  si;
        logic [31:0] sd;
        @(negedge clk);
        reset          = s_rst;
        bus.allocValid = s_av;
        bus.allocIndex = s_ai;
        bus.rs1Index   = s_r1;
        bus.rs2Index   = s_r2;
        bus.aluValid   = alu_pend;
        bus.aluIndex   = alu_i;
        bus.aluData    = alu_d;
        bus.lsuValid   = lsu_pend;
        bus.lsuIndex   = lsu_i;
        bus.lsuData    = lsu_d;
        #1;
        ar = !s_rst && (s_ai == 5'd0 || !mb[s_ai]);
        ga = !s_rst && alu_pend && (!lsu_pend || last_was_lsu);
        gl = !s_rst && lsu_pend && (!alu_pend || !last_was_lsu);
        chk("allocReady", 32'(bus.allocReady), 32'(ar));
        chk("rs1Busy",    32'(bus.rs1Busy),    32'(mb[s_r1]));
        chk("rs2Busy",    32'(bus.rs2Busy),    32'(mb[s_r2]));
        chk("aluReady",   32'(bus.aluReady),   32'(ga));
        chk("lsuReady",   32'(bus.lsuReady),   32'(gl));
        if (s_rst) begin
            foreach (mb[i]) mb[i] = 1'b0;
            last_was_lsu = 1'b1;
            out_we   = 1'b0;
            alu_pend = 1'b0;
            lsu_pend = 1'b0;
        end else begin
            if (out_we) mb[out_idx] = 1'b0;
            if (s_av && ar && s_ai != 5'd0) mb[s_ai] = 1'b1;
            out_we = 1'b0;
            if (ga || gl) begin
                if (ga) begin si = alu_i; sd = alu_d; alu_pend = 1'b0; last_was_lsu = 1'b0; end
                else    begin si = lsu_i; sd = lsu_d; lsu_pend = 1'b0; last_was_lsu = 1'b1; end
                if (si != 5'd0) begin
                    exp_q.push_back('{cyc + 1, si, sd});
                    out_we  = 1'b1;
                    out_idx = si;
                end
            end
        end
    endtask

    // Monitor: compare the registered write port against queued expectations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("we",         32'(bus.we),         32'(1));
                chk("writeIndex", 32'(bus.writeIndex), 32'(e.idx));
                chk("data",       bus.data,            e.dat);
            end else begin
                chk("we_idle", 32'(bus.we), 32'(0));
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.allocValid = 1'b0; bus.allocIndex = '0; bus.rs1Index = '0; bus.rs2Index = '0;
        bus.aluValid = 1'b0; bus.aluIndex = '0; bus.aluData = '0;
        bus.lsuValid = 1'b0; bus.lsuIndex = '0; bus.lsuData = '0;
        alu_pend = 1'b0; lsu_pend = 1'b0; last_was_lsu = 1'b1; out_we = 1'b0; out_idx = '0;
        alu_i = '0; lsu_i = '0; alu_d = '0; lsu_d = '0;
        foreach (mb[i]) mb[i] = 1'b0;

        idle_inputs(); s_rst = 1'b1; step(); step();
        chk("rst_writeIndex", 32'(bus.writeIndex), 32'(0));
        chk("rst_data",       bus.data,            32'(0));

        // Reserve x5, then RAW query and WAW re-reservation
        idle_inputs(); s_av = 1'b1; s_ai = 5'd5; step();
        s_r1 = 5'd5; step();
        // ALU writes x5; busy clears after the write cycle
        idle_inputs(); s_r1 = 5'd5; new_alu(5'd5, 32'hDEADBEEF); step();
        step(); step();

        // Both sources contend for four cycles after a fresh reset
        idle_inputs(); s_rst = 1'b1; step();
        idle_inputs(); s_av = 1'b1; s_ai = 5'd6; step();
        s_ai = 5'd7; s_r1 = 5'd6; step();
        idle_inputs(); s_r1 = 5'd6; s_r2 = 5'd7;
        for (int k = 0; k < 4; k++) begin
            if (!alu_pend) new_alu(5'd6, $urandom);
            if (!lsu_pend) new_lsu(5'd7, $urandom);
            step();
        end
        idle_inputs(); step(); step();

        // LSU write to x0 is discarded; alloc x0 always accepted
        idle_inputs(); s_av = 1'b1; s_ai = 5'd0; new_lsu(5'd0, 32'h1234); step();
        step(); step();

        // Alloc x9 with an ALU fire in flight, then a reset pulse
        idle_inputs(); s_av = 1'b1; s_ai = 5'd9; step();
        new_alu(5'd9, 32'hA5A5_0009); step();
        idle_inputs(); s_rst = 1'b1; s_av = 1'b1; s_ai = 5'd12; s_r1 = 5'd9;
        new_alu(5'd3, 32'h1); new_lsu(5'd4, 32'h2); step();
        idle_inputs(); s_r1 = 5'd9; step();

        // Alloc x3 while its write sits in the output stage
        idle_inputs(); s_av = 1'b1; s_ai = 5'd3; step();
        idle_inputs(); new_alu(5'd3, 32'h3333_3333); step();
        s_av = 1'b1; s_ai = 5'd3; step();
        step();
        idle_inputs(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 199) == 0);
            s_av  = $urandom_range(0, 1) == 1;
            s_ai  = 5'($urandom_range(0, 15));
            s_r1  = 5'($urandom_range(0, 31));
            s_r2  = 5'($urandom_range(0, 15));
            if (!alu_pend && $urandom_range(0, 9) < 6) new_alu(5'($urandom_range(0, 15)), $urandom);
            if (!lsu_pend && $urandom_range(0, 9) < 5) new_lsu(5'($urandom_range(0, 15)), $urandom);
            step();
        end

        idle_inputs(); step(); step(); step();
        chk("drain", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
